// File: rtl/snappy_job_scheduler.sv
// Descriptor FIFO plus one-job-at-a-time sequencer for the Snappy decompressor engine.
// Optional watchdog/abort path is built when SNAPPY_JOB_TIMEOUT_EN is defined.
module snappy_job_scheduler #(
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [ADDR_W-1:0]          job_src_addr,
  input  logic [ADDR_W-1:0]          job_des_addr,
  input  logic [LEN_W-1:0]           job_clen,
  input  logic [LEN_W-1:0]           job_dlen,
  input  logic [7:0]                 job_tag,
  input  logic                       eng_ready,
  input  logic                       eng_done,
  output logic                       eng_start,
  output logic [ADDR_W-1:0]          eng_src_addr,
  output logic [ADDR_W-1:0]          eng_des_addr,
  output logic [LEN_W-1:0]           eng_clen,
  output logic [LEN_W-1:0]           eng_dlen,
  output logic                       eng_soft_rst_n,
  output logic                       cmp_valid,
  input  logic                       cmp_ready,
  output logic [7:0]                 cmp_tag,
  output logic [1:0]                 cmp_status,
  output logic [31:0]                cmp_cycles,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 2 * ADDR_W + 2 * LEN_W + 8;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("snappy_job_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

`ifdef SNAPPY_JOB_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_REPORT, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_REPORT} state_t;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_count;
  logic [ADDR_W-1:0]   r_eng_src, r_eng_des;
  logic [LEN_W-1:0]    r_eng_clen, r_eng_dlen;
  logic [7:0]          r_tag_cur, r_cmp_tag;
  logic [1:0]          r_cmp_status;
  logic [31:0]         r_cyc, r_cmp_cycles;
  logic [31:0]         w_cyc_inc;
  logic                w_push, w_pop;
  logic [DW-1:0]       w_din, w_head;

  assign w_din     = {job_src_addr, job_des_addr, job_clen, job_dlen, job_tag};
  assign w_head    = r_mem[r_rd];
  assign job_ready = (r_count != CW'(DEPTH));
  assign w_push    = job_valid && job_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && eng_ready;
  assign w_cyc_inc = sat_inc(r_cyc);

`ifdef SNAPPY_JOB_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);
  logic [1:0] r_ab;
  logic       w_timeout;
  // Done beats the watchdog when both land on the same cycle.
  assign w_timeout      = (w_cyc_inc == TO_LIM) && !eng_done;
  assign eng_soft_rst_n = (r_state != S_ABORT);
`else
  assign eng_soft_rst_n = 1'b1;
`endif

  // Descriptor storage is plain RAM; only pointers and occupancy see reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN: begin
        if (eng_done) w_state_nxt = S_REPORT;
`ifdef SNAPPY_JOB_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = S_ABORT;
`endif
      end
`ifdef SNAPPY_JOB_TIMEOUT_EN
      S_ABORT:  if (r_ab == 2'd3) w_state_nxt = S_REPORT;
`endif
      S_REPORT: if (cmp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Launch registers, cycle counter and completion record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eng_src    <= '0;
      r_eng_des    <= '0;
      r_eng_clen   <= '0;
      r_eng_dlen   <= '0;
      r_tag_cur    <= '0;
      r_cyc        <= '0;
      r_cmp_tag    <= '0;
      r_cmp_status <= '0;
      r_cmp_cycles <= '0;
`ifdef SNAPPY_JOB_TIMEOUT_EN
      r_ab         <= '0;
`endif
    end else begin
      if (w_pop) begin
        {r_eng_src, r_eng_des, r_eng_clen, r_eng_dlen, r_tag_cur} <= w_head;
      end
      case (r_state)
        S_LAUNCH: r_cyc <= '0;
        S_RUN: begin
          r_cyc <= w_cyc_inc;
          if (eng_done) begin
            r_cmp_tag    <= r_tag_cur;
            r_cmp_status <= 2'b00;
            r_cmp_cycles <= w_cyc_inc;
          end
`ifdef SNAPPY_JOB_TIMEOUT_EN
          else if (w_timeout) begin
            r_cmp_tag    <= r_tag_cur;
            r_cmp_status <= 2'b01;
            r_cmp_cycles <= TO_LIM;
            r_ab         <= '0;
          end
`endif
        end
`ifdef SNAPPY_JOB_TIMEOUT_EN
        S_ABORT: r_ab <= r_ab + 2'd1;
`endif
        default: ;
      endcase
    end
  end

  assign eng_start    = (r_state == S_LAUNCH);
  assign cmp_valid    = (r_state == S_REPORT);
  assign eng_src_addr = r_eng_src;
  assign eng_des_addr = r_eng_des;
  assign eng_clen     = r_eng_clen;
  assign eng_dlen     = r_eng_dlen;
  assign cmp_tag      = r_cmp_tag;
  assign cmp_status   = r_cmp_status;
  assign cmp_cycles   = r_cmp_cycles;
  assign q_count      = r_count;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_snappy_job_scheduler.sv
// Directed bench for snappy_job_scheduler; inputs change and outputs are sampled on the falling edge.
// Define SNAPPY_JOB_TIMEOUT_EN to also exercise the watchdog path with TIMEOUT_CYC=100.
module tb_snappy_job_scheduler;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 32;
  localparam int DEPTH  = 4;
`ifdef SNAPPY_JOB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1048576;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid, job_ready;
  logic [ADDR_W-1:0] job_src_addr, job_des_addr;
  logic [LEN_W-1:0]  job_clen, job_dlen;
  logic [7:0]        job_tag;
  logic              eng_ready, eng_done, eng_start;
  logic [ADDR_W-1:0] eng_src_addr, eng_des_addr;
  logic [LEN_W-1:0]  eng_clen, eng_dlen;
  logic              eng_soft_rst_n;
  logic              cmp_valid, cmp_ready;
  logic [7:0]        cmp_tag;
  logic [1:0]        cmp_status;
  logic [31:0]       cmp_cycles;
  logic [2:0]        q_count;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int n_starts = 0;

  snappy_job_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src_addr(job_src_addr), .job_des_addr(job_des_addr),
    .job_clen(job_clen), .job_dlen(job_dlen), .job_tag(job_tag),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_start(eng_start),
    .eng_src_addr(eng_src_addr), .eng_des_addr(eng_des_addr),
    .eng_clen(eng_clen), .eng_dlen(eng_dlen), .eng_soft_rst_n(eng_soft_rst_n),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
    .cmp_status(cmp_status), .cmp_cycles(cmp_cycles),
    .q_count(q_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) n_starts <= n_starts + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] tag, input logic [63:0] src, input logic [63:0] des,
                      input logic [31:0] clen, input logic [31:0] dlen);
    int n;
    n = 0;
    job_tag = tag; job_src_addr = src; job_des_addr = des;
    job_clen = clen; job_dlen = dlen; job_valid = 1'b1;
    while (!job_ready && n < 50) begin step(); n++; end
    chk("push_ready", job_ready, 1);
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_start(input logic [63:0] src);
    int n;
    n = 0;
    while (!eng_start && n < 30) begin step(); n++; end
    chk("start_seen", eng_start, 1);
    chk("start_src", eng_src_addr, src);
  endtask

  task automatic finish_job(input logic [7:0] tag, input int delay, input int exp_cyc);
    repeat (delay) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("cmp_valid", cmp_valid, 1);
    chk("cmp_tag", cmp_tag, tag);
    chk("cmp_status", cmp_status, 2'b00);
    chk("cmp_cycles", cmp_cycles, 64'(exp_cyc));
    cmp_ready = 1'b1;
    step();
    cmp_ready = 1'b0;
    chk("cmp_retired", cmp_valid, 0);
  endtask

  initial begin
    int s0;
    int n;
    rst_n = 1'b0; job_valid = 1'b0; job_src_addr = '0; job_des_addr = '0;
    job_clen = '0; job_dlen = '0; job_tag = '0;
    eng_ready = 1'b0; eng_done = 1'b0; cmp_ready = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk("rst_job_ready", job_ready, 1);
    chk("rst_soft_rst_n", eng_soft_rst_n, 1);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_src", eng_src_addr, 0);
    chk("rst_cmp_cycles", cmp_cycles, 0);
    rst_n = 1'b1;
    step();

    // Single job: start two cycles after accept, done 50 cycles after start.
    eng_ready = 1'b1;
    push(8'h11, 64'h1000, 64'h2000, 32'd64, 32'd256);
    chk("t1_q_after_push", q_count, 1);
    chk("t1_no_start_yet", eng_start, 0);
    step();
    chk("t1_start", eng_start, 1);
    chk("t1_src", eng_src_addr, 64'h1000);
    chk("t1_des", eng_des_addr, 64'h2000);
    chk("t1_clen", eng_clen, 64);
    chk("t1_q_popped", q_count, 0);
    step();
    chk("t1_start_one_cycle", eng_start, 0);
    finish_job(8'h11, 49, 50);
    chk("t1_one_start", n_starts, 1);
    chk("t1_idle_busy", busy, 0);

    // Backpressure on the completion channel.
    push(8'h21, 64'h2100, 64'h2110, 32'd1, 32'd2);
    push(8'h22, 64'h2200, 64'h2210, 32'd3, 32'd4);
    wait_start(64'h2100);
    repeat (30) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("bp_cmp_valid", cmp_valid, 1);
    s0 = n_starts;
    repeat (20) step();
    chk("bp_valid_held", cmp_valid, 1);
    chk("bp_tag_held", cmp_tag, 8'h21);
    chk("bp_cycles_held", cmp_cycles, 30);
    chk("bp_no_new_start", n_starts, s0);
    chk("bp_q_waiting", q_count, 1);
    cmp_ready = 1'b1;
    step();
    cmp_ready = 1'b0;
    chk("bp_h1_no_start", eng_start, 0);
    chk("bp_h1_cmp_low", cmp_valid, 0);
    step();
    chk("bp_h2_start", eng_start, 1);
    chk("bp_h2_src", eng_src_addr, 64'h2200);
    finish_job(8'h22, 7, 7);

    // Fill the queue while the engine reports not ready; fifth waits for a pop.
    eng_ready = 1'b0;
    for (int t = 1; t <= 4; t++)
      push(8'(t), 64'(t * 256), 64'(t * 4096), 32'(t), 32'(t * 2));
    chk("fill_q4", q_count, 4);
    chk("fill_not_ready", job_ready, 0);
    chk("fill_busy", busy, 1);
    job_tag = 8'd5; job_src_addr = 64'(5 * 256); job_des_addr = 64'(5 * 4096);
    job_clen = 32'd5; job_dlen = 32'd10; job_valid = 1'b1;
    repeat (3) step();
    chk("fill_q_held", q_count, 4);
    eng_ready = 1'b1;
    step();
    chk("fill_pop_start", eng_start, 1);
    chk("fill_pop_src", eng_src_addr, 64'h100);
    chk("fill_pop_q3", q_count, 3);
    chk("fill_ready_again", job_ready, 1);
    step();
    job_valid = 1'b0;
    chk("fill_fifth_in", q_count, 4);
    finish_job(8'd1, 9, 10);
    for (int t = 2; t <= 5; t++) begin
      wait_start(64'(t * 256));
      chk("fill_des", eng_des_addr, 64'(t * 4096));
      finish_job(8'(t), 5 + t, 5 + t);
    end

    // Simultaneous push and pop with one entry queued.
    eng_ready = 1'b0;
    push(8'h31, 64'h3100, 64'h3200, 32'h31, 32'h310);
    chk("pp_q1", q_count, 1);
    job_tag = 8'h32; job_src_addr = 64'hAAAA_0000_0000_3300; job_des_addr = 64'h5555_0000_0000_3400;
    job_clen = 32'hFFFF_FFFF; job_dlen = 32'h8000_0001; job_valid = 1'b1;
    eng_ready = 1'b1;
    step();
    job_valid = 1'b0;
    chk("pp_q_stays1", q_count, 1);
    chk("pp_start", eng_start, 1);
    chk("pp_src31", eng_src_addr, 64'h3100);
    chk("pp_dlen31", eng_dlen, 32'h310);
    finish_job(8'h31, 3, 3);
    wait_start(64'hAAAA_0000_0000_3300);
    chk("pp_des32", eng_des_addr, 64'h5555_0000_0000_3400);
    chk("pp_clen32", eng_clen, 32'hFFFF_FFFF);
    chk("pp_dlen32", eng_dlen, 32'h8000_0001);
    finish_job(8'h32, 4, 4);

    // Reset while a job runs: job dropped, queue emptied.
    push(8'h41, 64'h4100, 64'h4200, 32'd9, 32'd9);
    wait_start(64'h4100);
    push(8'h42, 64'h4300, 64'h4400, 32'd9, 32'd9);
    repeat (3) step();
    chk("rr_q_before", q_count, 1);
    rst_n = 1'b0;
    step();
    chk("rr_start", eng_start, 0);
    chk("rr_cmp_valid", cmp_valid, 0);
    chk("rr_q0", q_count, 0);
    chk("rr_job_ready", job_ready, 1);
    chk("rr_soft_rst_n", eng_soft_rst_n, 1);
    chk("rr_eng_src", eng_src_addr, 0);
    chk("rr_busy", busy, 0);
    rst_n = 1'b1;
    s0 = n_starts;
    eng_done = 1'b1;
    repeat (5) step();
    eng_done = 1'b0;
    chk("rr_no_cmp", cmp_valid, 0);
    chk("rr_no_start", n_starts, s0);
    chk("rr_q_still0", q_count, 0);

`ifdef SNAPPY_JOB_TIMEOUT_EN
    // Watchdog: engine never finishes the first job.
    push(8'h51, 64'h5100, 64'h5200, 32'd1, 32'd1);
    push(8'h52, 64'h5300, 64'h5400, 32'd1, 32'd1);
    wait_start(64'h5100);
    n = 0;
    while (eng_soft_rst_n && n < 150) begin step(); n++; end
    chk("to_enter_abort", n, 101);
    n = 0;
    while (!eng_soft_rst_n && n < 10) begin step(); n++; end
    chk("to_soft_rst_len", n, 4);
    chk("to_cmp_valid", cmp_valid, 1);
    chk("to_cmp_tag", cmp_tag, 8'h51);
    chk("to_status", cmp_status, 2'b01);
    chk("to_cycles", cmp_cycles, 100);
    cmp_ready = 1'b1;
    step();
    cmp_ready = 1'b0;
    wait_start(64'h5300);
    finish_job(8'h52, 6, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
